// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble). It processes one input bit per clock, so a conversion takes
// BIN_W cycles from an accepted start to the done pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    request conversion of bin_in; sampled only while idle
//   bin_in   unsigned binary value, captured on an accepted start
//   busy     conversion in progress
//   done     one-cycle pulse: bcd_out/overflow were updated this cycle
//   bcd_out  result; digit k = bcd_out[4k+3:4k], digit 0 = ones
//   overflow value exceeded 10^DIGITS-1; valid with done
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   sreg, sreg_nxt;
  logic [BCD_W-1:0]   scratch, scratch_nxt;
  logic               ovf_acc, ovf_acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic               overflow_nxt;

  // Datapath for one dabble step: add 3 to every digit >= 5, then shift the
  // shift-register MSB into digit 0. Bit BCD_W is the bit leaving the top digit.
  logic [BCD_W-1:0]   adj;
  logic [BCD_W:0]     shifted;

  always_comb begin : dabble_step
    adj = scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
    shifted = {adj, sreg[BIN_W-1]};
  end

  // Next-state and next-output logic.
  always_comb begin : next_logic
    state_nxt    = state;
    sreg_nxt     = sreg;
    scratch_nxt  = scratch;
    ovf_acc_nxt  = ovf_acc;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    bcd_nxt      = bcd_out;
    overflow_nxt = overflow;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          sreg_nxt    = bin_in;
          scratch_nxt = '0;
          ovf_acc_nxt = 1'b0;
          cnt_nxt     = CNT_W'(BIN_W);
          busy_nxt    = 1'b1;
        end
      end
      SHIFT: begin
        scratch_nxt = shifted[BCD_W-1:0];
        sreg_nxt    = BIN_W'(sreg << 1);
        ovf_acc_nxt = ovf_acc | shifted[BCD_W];
        cnt_nxt     = cnt - CNT_W'(1);
        // Last shift: publish the freshly shifted value so the result never
        // appears partially on bcd_out.
        if (cnt == CNT_W'(1)) begin
          state_nxt    = IDLE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          bcd_nxt      = shifted[BCD_W-1:0];
          overflow_nxt = ovf_acc | shifted[BCD_W];
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      scratch  <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      scratch  <= scratch_nxt;
      ovf_acc  <= ovf_acc_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      bcd_out  <= bcd_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: a 5-digit instance and a 4-digit
// instance (for overflow) share clock and reset.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start,  start4;
  logic [15:0] bin_in, bin4;
  logic        busy,   busy4;
  logic        done,   done4;
  logic [19:0] bcd_out;
  logic [15:0] bcd4;
  logic        overflow, overflow4;

  int checks   = 0;
  int failures = 0;
  int n;
  int bcnt;
  int dcnt;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(overflow4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge (the accept edge E0) on the selected instance.
  task automatic start_conv(input bit four, input logic [15:0] v);
    if (four) begin start4 = 1'b1; bin4 = v; end
    else      begin start  = 1'b1; bin_in = v; end
    tick();
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Count edges until done (bounded); bc counts busy=1 samples before done.
  task automatic wait_done(input bit four, output int edges, output int bc);
    logic d, b;
    edges = 0;
    bc = (four ? busy4 : busy) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      edges++;
      d = four ? done4 : done;
      b = four ? busy4 : busy;
      if (d) break;
      if (b) bc++;
    end
    if (!(four ? done4 : done)) begin
      checks++;
      failures++;
      $error("FAIL done_timeout observed=0 expected=1");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; bin_in = '0; bin4 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bcd4", 32'(bcd4), 32'd0);
    tick();

    // 1: zero converts in exactly 16 edges
    start_conv(1'b0, 16'd0);
    check("t1_busy_e0", 32'(busy), 32'd1);
    wait_done(1'b0, n, bcnt);
    check("t1_latency", 32'(n), 32'd16);
    check("t1_bcd", 32'(bcd_out), 32'h00000);
    check("t1_ovf", 32'(overflow), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2: full-scale value
    start_conv(1'b0, 16'hFFFF);
    wait_done(1'b0, n, bcnt);
    check("t2_latency", 32'(n), 32'd16);
    check("t2_busy_cycles", 32'(bcnt), 32'd16);
    check("t2_busy_at_done", 32'(busy), 32'd0);
    check("t2_bcd", 32'(bcd_out), 32'h65535);
    check("t2_ovf", 32'(overflow), 32'd0);
    tick();
    check("t2_done_pulse", 32'(done), 32'd0);
    check("t2_hold", 32'(bcd_out), 32'h65535);

    // 3: start while busy is ignored
    start_conv(1'b0, 16'd1234);
    tick();
    start = 1'b1; bin_in = 16'd9;
    tick();
    start = 1'b0;
    check("t3_hold_midway", 32'(bcd_out), 32'h65535);
    wait_done(1'b0, n, bcnt);
    check("t3_latency", 32'(n + 2), 32'd16);
    check("t3_bcd", 32'(bcd_out), 32'h01234);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("t3_no_second_done", 32'(dcnt), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);

    // 4: reset mid-conversion abandons it
    start_conv(1'b0, 16'd999);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_bcd", 32'(bcd_out), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("t4_no_done", 32'(dcnt), 32'd0);
    start_conv(1'b0, 16'd42);
    wait_done(1'b0, n, bcnt);
    check("t4_bcd42", 32'(bcd_out), 32'h00042);
    tick();

    // 5: back-to-back start in the done cycle
    start_conv(1'b0, 16'd7);
    wait_done(1'b0, n, bcnt);
    check("t5_bcd7", 32'(bcd_out), 32'h00007);
    start_conv(1'b0, 16'd10);
    check("t5_busy_again", 32'(busy), 32'd1);
    check("t5_hold7", 32'(bcd_out), 32'h00007);
    wait_done(1'b0, n, bcnt);
    check("t5_spacing", 32'(n), 32'd16);
    check("t5_bcd10", 32'(bcd_out), 32'h00010);
    tick();

    // Extra: a mid-range value with mixed digits
    start_conv(1'b0, 16'd50809);
    wait_done(1'b0, n, bcnt);
    check("tx_bcd", 32'(bcd_out), 32'h50809);
    check("tx_ovf", 32'(overflow), 32'd0);

    // 6: four-digit instance, overflow then in-range
    start_conv(1'b1, 16'd12345);
    wait_done(1'b1, n, bcnt);
    check("t6_latency", 32'(n), 32'd16);
    check("t6_bcd", 32'(bcd4), 32'h2345);
    check("t6_ovf", 32'(overflow4), 32'd1);
    tick();
    check("t6_ovf_hold", 32'(overflow4), 32'd1);
    start_conv(1'b1, 16'd9999);
    wait_done(1'b1, n, bcnt);
    check("t6_bcd9999", 32'(bcd4), 32'h9999);
    check("t6_ovf9999", 32'(overflow4), 32'd0);
    start_conv(1'b1, 16'd10000);
    wait_done(1'b1, n, bcnt);
    check("t6_bcd10000", 32'(bcd4), 32'h0000);
    check("t6_ovf10000", 32'(overflow4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
